// File: rtl/integrator_pkg.sv
// ----------------------------------------------------------------------------
// integrator_pkg
// Shared definitions for the multi-axis gyro integrator:
//   state_t     - controller states (idle / calibrating / running)
//   HDG_W       - width of each reported heading (top bits of the accumulator)
//   CAL_FRAC_W  - fractional bits carried by the compensated rate (1/8 LSB)
//   acc_width() - accumulator width derived from the raw rate width
// ----------------------------------------------------------------------------
package integrator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAL  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int HDG_W      = 12;
    localparam int CAL_FRAC_W = 3;

    // Accumulator width: one full turn maps onto 2^acc_width counts.
    function automatic int acc_width(input int data_w);
        return data_w + 11;
    endfunction

endpackage

// File: rtl/multi_axis_integrator_if.sv
// ----------------------------------------------------------------------------
// multi_axis_integrator_if
// Bundles the control, rate and result signals of multi_axis_integrator.
//   master : drives strt_cal, zero_hdg, vld, rate, lftIR, rghtIR, moving;
//            observes cal_done, cal_err, rdy, heading
//   slave  : the integrator itself (mirror image of master)
// rate and heading are packed with axis 0 in the LSBs.
// ----------------------------------------------------------------------------
interface multi_axis_integrator_if
    import integrator_pkg::*;
#(
    parameter int NUM_AXES = 2,
    parameter int DATA_W   = 16
);
    logic                         strt_cal;
    logic                         zero_hdg;
    logic                         vld;
    logic [NUM_AXES*DATA_W-1:0]   rate;
    logic                         lftIR;
    logic                         rghtIR;
    logic                         moving;
    logic                         cal_done;
    logic                         cal_err;
    logic                         rdy;
    logic [NUM_AXES*HDG_W-1:0]    heading;

    modport master (
        output strt_cal, zero_hdg, vld, rate, lftIR, rghtIR, moving,
        input  cal_done, cal_err, rdy, heading
    );

    modport slave (
        input  strt_cal, zero_hdg, vld, rate, lftIR, rghtIR, moving,
        output cal_done, cal_err, rdy, heading
    );

endinterface

// File: rtl/integrator_axis.sv
// ----------------------------------------------------------------------------
// integrator_axis
// One gyro axis: rate compensation (stage 1), scaling and accumulation
// (stage 2) and the calibration offset register.
//   clk, rst_n  : clock, asynchronous active-low reset
//   cap_en      : capture a new compensated rate into stage 1
//   run_mode    : compensate against the offset (otherwise raw, extended)
//   raw         : signed raw rate
//   integ_en    : add the stage-1 value (plus fuse) into the accumulator
//   scale_en    : apply the 31/32 gain to the stage-1 value
//   fuse        : extra signed correction added with the integrate
//   acc_clr     : clear the accumulator (wins over integ_en)
//   off_load    : load the offset from the accumulator (calibration result)
//   heading     : top HDG_W bits of the accumulator
// ----------------------------------------------------------------------------
module integrator_axis
    import integrator_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int CAL_LOG2 = 11
)
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cap_en,
    input  logic                       run_mode,
    input  logic signed [DATA_W-1:0]   raw,
    input  logic                       integ_en,
    input  logic                       scale_en,
    input  logic signed [DATA_W+2:0]   fuse,
    input  logic                       acc_clr,
    input  logic                       off_load,
    output logic [HDG_W-1:0]           heading
);

    localparam int CW     = DATA_W + CAL_FRAC_W;
    localparam int ACC_W  = acc_width(DATA_W);
    localparam int OFF_SH = CAL_LOG2 - CAL_FRAC_W;

    logic signed [CW-1:0]    raw_ext_s;
    logic signed [CW-1:0]    comp_s;
    logic signed [CW-1:0]    s1_comp_r;
    logic signed [CW-1:0]    offset_r;
    logic signed [CW+4:0]    comp_ext_s;
    logic signed [CW+4:0]    prod_s;
    logic signed [CW-1:0]    scaled_s;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] sum_s;

    // Compensation: raw sample in calibration, 1/8-LSB offset-corrected rate when running.
    always_comb begin
        raw_ext_s = {{CAL_FRAC_W{raw[DATA_W-1]}}, raw};
        if (run_mode) begin
            comp_s = {raw, {CAL_FRAC_W{1'b0}}} - offset_r;
        end else begin
            comp_s = raw_ext_s;
        end
    end

    // Gain of 31/32 built as (x*32 - x) >>> 5, so no multiplier is needed.
    always_comb begin
        comp_ext_s = {{5{s1_comp_r[CW-1]}}, s1_comp_r};
        prod_s     = (comp_ext_s <<< 5) - comp_ext_s;
        if (scale_en) begin
            scaled_s = CW'(prod_s >>> 5);
        end else begin
            scaled_s = s1_comp_r;
        end
        sum_s = acc_r
              + {{(ACC_W-CW){scaled_s[CW-1]}}, scaled_s}
              + {{(ACC_W-CW){fuse[CW-1]}}, fuse};
    end

    // Stage-1 capture, wrapping accumulator and offset register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_comp_r <= {CW{1'b0}};
            acc_r     <= {ACC_W{1'b0}};
            offset_r  <= {CW{1'b0}};
        end else begin
            if (cap_en) begin
                s1_comp_r <= comp_s;
            end
            if (acc_clr) begin
                acc_r <= {ACC_W{1'b0}};
            end else if (integ_en) begin
                acc_r <= sum_s;
            end
            // The accumulator holds the sum of 2^CAL_LOG2 raw samples; rescale to 1/8 LSB.
            if (off_load) begin
                offset_r <= CW'(acc_r >>> OFF_SH);
            end
        end
    end

    assign heading = acc_r[ACC_W-1 -: HDG_W];

endmodule

// File: rtl/multi_axis_integrator.sv
// ----------------------------------------------------------------------------
// multi_axis_integrator
// Integrates NUM_AXES signed gyro rates into headings after a calibration
// that learns each axis' zero-rate offset. Guardrail IR sensors nudge axis 0.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : multi_axis_integrator_if slave port
//                strt_cal  start/restart calibration
//                zero_hdg  clear headings while running
//                vld       one-cycle strobe, rate valid on all axes
//                rate      packed signed rates, axis 0 in LSBs
//                lftIR/rghtIR guardrail sensors (axis 0 correction)
//                moving    integrate only while high (running)
//                cal_done  one-cycle pulse on successful calibration
//                cal_err   level, calibration timed out
//                rdy       one-cycle pulse, headings updated this cycle
//                heading   packed signed headings, axis 0 in LSBs
// ----------------------------------------------------------------------------
module multi_axis_integrator
    import integrator_pkg::*;
#(
    parameter int                    NUM_AXES    = 2,
    parameter int                    DATA_W      = 16,
    parameter int                    CAL_LOG2    = 11,
    parameter int                    CAL_TIMEOUT = 32'h0040_0000,
    parameter logic [DATA_W+2:0]     FUSION_STEP = 19'h03000
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    multi_axis_integrator_if.slave   bus
);

    localparam int CW    = DATA_W + CAL_FRAC_W;
    localparam int SMP_W = CAL_LOG2 + 1;
    localparam int TMO_W = $clog2(CAL_TIMEOUT + 1);
    localparam logic [SMP_W-1:0] SMP_FULL = {1'b1, {CAL_LOG2{1'b0}}};

    state_t                   state_r;
    state_t                   s1_state_r;
    logic                     s1_vld_r;
    logic [SMP_W-1:0]         smp_cnt_r;
    logic [TMO_W-1:0]         tmo_cnt_r;
    logic                     cal_done_r;
    logic                     cal_err_r;
    logic                     rdy_r;

    logic                     cal_full_s;
    logic                     tmo_hit_s;
    logic                     acc_clr_s;
    logic                     off_load_s;
    logic                     integ_s;
    logic                     scale_s;
    logic                     cal_smp_s;
    logic signed [CW-1:0]     fuse_s;
    logic [NUM_AXES*HDG_W-1:0] hdg_all_s;

    assign cal_full_s = (smp_cnt_r == SMP_FULL);
    assign tmo_hit_s  = (tmo_cnt_r == TMO_W'(CAL_TIMEOUT - 1));

    // Per-cycle datapath control. A stage-1 sample is only integrated in the
    // state it was captured in, so a sample straddling a state change is dropped.
    always_comb begin
        acc_clr_s  = 1'b0;
        off_load_s = 1'b0;
        integ_s    = 1'b0;
        scale_s    = 1'b0;
        cal_smp_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.strt_cal) begin
                    acc_clr_s = 1'b1;
                end else begin
                    acc_clr_s = 1'b0;
                end
            end
            ST_CAL: begin
                if (bus.strt_cal) begin
                    acc_clr_s = 1'b1;
                end else if (cal_full_s) begin
                    acc_clr_s  = 1'b1;
                    off_load_s = 1'b1;
                end else if (tmo_hit_s) begin
                    acc_clr_s = 1'b0;
                end else if (s1_vld_r && (s1_state_r == ST_CAL)) begin
                    integ_s   = 1'b1;
                    cal_smp_s = 1'b1;
                end else begin
                    integ_s = 1'b0;
                end
            end
            ST_RUN: begin
                // strt_cal and zero_hdg both clear; strt_cal's state change is in the FSM.
                if (bus.strt_cal || bus.zero_hdg) begin
                    acc_clr_s = 1'b1;
                end else if (s1_vld_r && (s1_state_r == ST_RUN) && bus.moving) begin
                    integ_s = 1'b1;
                    scale_s = 1'b1;
                end else begin
                    integ_s = 1'b0;
                end
            end
            default: begin
                acc_clr_s = 1'b0;
            end
        endcase
    end

    // Guardrail correction for axis 0: one-sided IR contact steers, both/neither is neutral.
    always_comb begin
        if ((state_r == ST_RUN) && bus.lftIR && !bus.rghtIR) begin
            fuse_s = FUSION_STEP;
        end else if ((state_r == ST_RUN) && !bus.lftIR && bus.rghtIR) begin
            fuse_s = -FUSION_STEP;
        end else begin
            fuse_s = {CW{1'b0}};
        end
    end

    // Controller FSM, calibration counters, pipeline valid and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            s1_state_r <= ST_IDLE;
            s1_vld_r   <= 1'b0;
            smp_cnt_r  <= {SMP_W{1'b0}};
            tmo_cnt_r  <= {TMO_W{1'b0}};
            cal_done_r <= 1'b0;
            cal_err_r  <= 1'b0;
            rdy_r      <= 1'b0;
        end else begin
            s1_vld_r   <= bus.vld;
            s1_state_r <= state_r;
            rdy_r      <= s1_vld_r;
            cal_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.strt_cal) begin
                        state_r   <= ST_CAL;
                        smp_cnt_r <= {SMP_W{1'b0}};
                        tmo_cnt_r <= {TMO_W{1'b0}};
                        cal_err_r <= 1'b0;
                    end
                end
                ST_CAL: begin
                    if (bus.strt_cal) begin
                        smp_cnt_r <= {SMP_W{1'b0}};
                        tmo_cnt_r <= {TMO_W{1'b0}};
                        cal_err_r <= 1'b0;
                    end else if (cal_full_s) begin
                        state_r    <= ST_RUN;
                        cal_done_r <= 1'b1;
                        smp_cnt_r  <= {SMP_W{1'b0}};
                        tmo_cnt_r  <= {TMO_W{1'b0}};
                    end else if (tmo_hit_s) begin
                        state_r   <= ST_IDLE;
                        cal_err_r <= 1'b1;
                        smp_cnt_r <= {SMP_W{1'b0}};
                        tmo_cnt_r <= {TMO_W{1'b0}};
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1'b1);
                        if (cal_smp_s) begin
                            smp_cnt_r <= smp_cnt_r + SMP_W'(1'b1);
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.strt_cal) begin
                        state_r   <= ST_CAL;
                        smp_cnt_r <= {SMP_W{1'b0}};
                        tmo_cnt_r <= {TMO_W{1'b0}};
                        cal_err_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
        integrator_axis #(
            .DATA_W   (DATA_W),
            .CAL_LOG2 (CAL_LOG2)
        ) u_axis (
            .clk      (clk),
            .rst_n    (rst_n),
            .cap_en   (bus.vld),
            .run_mode (state_r == ST_RUN),
            .raw      (bus.rate[a*DATA_W +: DATA_W]),
            .integ_en (integ_s),
            .scale_en (scale_s),
            .fuse     ((a == 0) ? fuse_s : {CW{1'b0}}),
            .acc_clr  (acc_clr_s),
            .off_load (off_load_s),
            .heading  (hdg_all_s[a*HDG_W +: HDG_W])
        );
    end

    assign bus.cal_done = cal_done_r;
    assign bus.cal_err  = cal_err_r;
    assign bus.rdy      = rdy_r;
    assign bus.heading  = hdg_all_s;

endmodule

// File: tb/tb_multi_axis_integrator.sv
// ----------------------------------------------------------------------------
// tb_multi_axis_integrator
// Scoreboard bench: every vld pushes the expected heading and rdy cycle into
// a queue; a monitor pops and compares on each rdy. Per-vld accumulator
// increments are hand-derived constants for each scenario.
// ----------------------------------------------------------------------------
module tb_multi_axis_integrator;
    import integrator_pkg::*;

    localparam int NA = 2;
    localparam int DW = 16;

    typedef struct {
        int          cyc;
        logic [23:0] hdg;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          checks;
    int          failures;
    int          cyc;
    int          cal_done_cnt;
    int          cal_done_cyc;
    int          last_vld_cyc;
    exp_t        exp_q[$];
    logic [26:0] acc_m [NA];

    multi_axis_integrator_if #(.NUM_AXES(NA), .DATA_W(DW)) bus ();

    multi_axis_integrator #(
        .NUM_AXES    (NA),
        .DATA_W      (DW),
        .CAL_LOG2    (3),
        .CAL_TIMEOUT (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] exp_hdg();
        return {acc_m[1][26:15], acc_m[0][26:15]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        acc_m[0] = 27'h0;
        acc_m[1] = 27'h0;
    endtask

    task automatic send_vld(input logic [15:0] r, input logic [26:0] inc0,
                            input logic [26:0] inc1, input int gap);
        bus.rate = {r, r};
        bus.vld  = 1'b1;
        acc_m[0] = acc_m[0] + inc0;
        acc_m[1] = acc_m[1] + inc1;
        exp_q.push_back('{cyc + 2, exp_hdg()});
        last_vld_cyc = cyc;
        tick();
        bus.vld = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_strt();
        bus.strt_cal = 1'b1;
        tick();
        bus.strt_cal = 1'b0;
        clear_model();
    endtask

    task automatic calibrate(input logic [15:0] r);
        int n0;
        n0 = cal_done_cnt;
        pulse_strt();
        for (int i = 0; i < 8; i++) begin
            send_vld(r, {{11{r[15]}}, r}, {{11{r[15]}}, r}, 1);
        end
        repeat (4) tick();
        chk("cal_done_count", cal_done_cnt, n0 + 1);
        chk("cal_done_cycle", cal_done_cyc, last_vld_cyc + 3);
        chk("state_running", 32'(dut.state_r), 32'(ST_RUN));
        clear_model();
    endtask

    // Monitor: pops one expectation per rdy and flags late or unexpected pulses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.cal_done) begin
                    cal_done_cnt++;
                    cal_done_cyc = cyc;
                end
                if (bus.rdy) begin
                    if (exp_q.size() == 0) begin
                        chk("rdy_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rdy_cycle", cyc, e.cyc);
                        chk("heading", {8'h00, bus.heading}, {8'h00, e.hdg});
                    end
                end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
                    e = exp_q.pop_front();
                    chk("rdy_missing", 32'd0, 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d limit=20000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        cal_done_cnt = 0;
        cal_done_cyc = -1;
        last_vld_cyc = 0;
        clear_model();
        rst_n        = 1'b0;
        bus.strt_cal = 1'b0;
        bus.zero_hdg = 1'b0;
        bus.vld      = 1'b0;
        bus.rate     = 32'h0;
        bus.lftIR    = 1'b0;
        bus.rghtIR   = 1'b0;
        bus.moving   = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_heading", {8'h00, bus.heading}, 32'h0);
        chk("rst_cal_done", {31'h0, bus.cal_done}, 32'h0);
        chk("rst_cal_err", {31'h0, bus.cal_err}, 32'h0);
        chk("rst_rdy", {31'h0, bus.rdy}, 32'h0);
        chk("rst_state", 32'(dut.state_r), 32'(ST_IDLE));
        rst_n = 1'b1;
        tick();

        // vld in IDLE: rdy pulses, headings untouched
        send_vld(16'h1000, 27'h0, 27'h0, 2);
        drain();

        // Calibrate at 0x0010 -> offset 0x80; running at the same rate stays put
        calibrate(16'h0010);
        chk("offset_ax0", 32'(dut.g_axis[0].u_axis.offset_r), 32'h80);
        chk("offset_ax1", 32'(dut.g_axis[1].u_axis.offset_r), 32'h80);
        bus.moving = 1'b1;
        repeat (16) send_vld(16'h0010, 27'h0, 27'h0, 1);
        drain();
        chk("hdg_zero_rate", {8'h00, bus.heading}, 32'h0);

        // Offset 0, rate 0x1000: 0x8000*31>>5 = 0x7C00 per sample, mixed back-to-back
        calibrate(16'h0000);
        chk("offset_zero", 32'(dut.g_axis[0].u_axis.offset_r), 32'h0);
        for (int i = 0; i < 32; i++) begin
            send_vld(16'h1000, 27'h7C00, 27'h7C00, (i % 4 == 0) ? 1 : 0);
        end
        drain();
        chk("hdg_32", {8'h00, bus.heading}, 32'h01F01F);
        bus.moving = 1'b0;
        repeat (4) send_vld(16'h1000, 27'h0, 27'h0, 2);
        drain();
        chk("hdg_not_moving", {8'h00, bus.heading}, 32'h01F01F);

        // Guardrail fusion on axis 0 only
        bus.moving = 1'b1;
        calibrate(16'h0010);
        bus.lftIR  = 1'b1;
        bus.rghtIR = 1'b0;
        repeat (8) send_vld(16'h0010, 27'h3000, 27'h0, 1);
        drain();
        chk("fusion_left", {8'h00, bus.heading}, 32'h000003);
        bus.rghtIR = 1'b1;
        repeat (4) send_vld(16'h0010, 27'h0, 27'h0, 1);
        drain();
        chk("fusion_both", {8'h00, bus.heading}, 32'h000003);
        bus.lftIR = 1'b0;
        repeat (16) send_vld(16'h0010, 27'h7FFD000, 27'h0, 1);
        drain();
        chk("fusion_right_wrap", {8'h00, bus.heading}, 32'h000FFD);
        bus.rghtIR = 1'b0;

        // zero_hdg clears headings, offsets kept (0x8000-0x80 -> 0x7B84 per sample)
        bus.zero_hdg = 1'b1;
        tick();
        bus.zero_hdg = 1'b0;
        clear_model();
        chk("zero_hdg", {8'h00, bus.heading}, 32'h0);
        chk("zero_keeps_offset", 32'(dut.g_axis[0].u_axis.offset_r), 32'h80);
        repeat (2) send_vld(16'h1000, 27'h7B84, 27'h7B84, 1);
        drain();
        chk("hdg_after_zero", {8'h00, bus.heading}, 32'h001001);

        // strt_cal wins over zero_hdg
        bus.strt_cal = 1'b1;
        bus.zero_hdg = 1'b1;
        tick();
        bus.strt_cal = 1'b0;
        bus.zero_hdg = 1'b0;
        clear_model();
        chk("strt_over_zero", 32'(dut.state_r), 32'(ST_CAL));

        // Calibration timeout: only 3 samples within 64 clocks
        begin
            int n0;
            n0 = cal_done_cnt;
            repeat (3) send_vld(16'h0010, 27'h10, 27'h10, 2);
            chk("cal_err_pre", {31'h0, bus.cal_err}, 32'h0);
            repeat (70) tick();
            chk("cal_err_set", {31'h0, bus.cal_err}, 32'h1);
            chk("tmo_state_idle", 32'(dut.state_r), 32'(ST_IDLE));
            chk("tmo_no_done", cal_done_cnt, n0);
        end
        pulse_strt();
        chk("cal_err_clr", {31'h0, bus.cal_err}, 32'h0);
        chk("restart_state", 32'(dut.state_r), 32'(ST_CAL));

        // Reset in the middle of calibration
        repeat (5) send_vld(16'h0010, 27'h10, 27'h10, 1);
        drain();
        rst_n = 1'b0;
        clear_model();
        repeat (2) tick();
        chk("mid_rst_heading", {8'h00, bus.heading}, 32'h0);
        chk("mid_rst_cal_done", {31'h0, bus.cal_done}, 32'h0);
        chk("mid_rst_cal_err", {31'h0, bus.cal_err}, 32'h0);
        chk("mid_rst_rdy", {31'h0, bus.rdy}, 32'h0);
        chk("mid_rst_state", 32'(dut.state_r), 32'(ST_IDLE));
        chk("mid_rst_offset", 32'(dut.g_axis[0].u_axis.offset_r), 32'h0);
        rst_n = 1'b1;
        tick();
        calibrate(16'h0010);
        chk("recal_offset", 32'(dut.g_axis[1].u_axis.offset_r), 32'h80);

        drain();
        chk("queue_empty", exp_q.size(), 32'h0);
        chk("cal_done_total", cal_done_cnt, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
